// File: rtl/mpu_ls_controller.sv
// Load/store sequencer for the MPU: accepts one command, validates it, drives the load/store unit enables and reports done/error.
// Latency: NOP or rejected command reaches done/error 2 cycles after accept; LOAD/STORE add the ack/complete wait (done 1 cycle after it is sampled).
// Backpressure: cmd_ready_out is high only in IDLE, so exactly one command is in flight at a time.
//
// Ports: clk/rst (async active-low); cmd_* command port (valid/ready); load_en_out/mem_load_* to the load unit;
//        store_en_out/reg_store_*_out/in to the store path; busy/done/error/err_code status; reg_valid_out loaded-register flags.
// Optional feature: define MPU_CTRL_TIMEOUT_EN to add a watchdog (TIMEOUT_CYCLES) on LOAD_RUN/STORE_RUN, reported as error code 5.
module mpu_ls_controller #(
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_SIZE = 2,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid_in,
    output logic                          cmd_ready_out,
    input  logic [1:0]                    cmd_op_in,
    input  logic [MATRIX_REG_SIZE-1:0]    cmd_addr_in,
    input  logic [MBITS:0]                cmd_m_in,
    input  logic [NBITS:0]                cmd_n_in,
    output logic                          load_en_out,
    input  logic                          mem_load_ack_in,
    input  logic                          mem_load_error_in,
    output logic                          store_en_out,
    output logic [MATRIX_REG_SIZE-1:0]    reg_store_addr_out,
    input  logic                          reg_store_complete_in,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out,
    output logic [2:0]                    err_code_out,
    output logic [2**MATRIX_REG_SIZE-1:0] reg_valid_out
);

    localparam int NREG = 2**MATRIX_REG_SIZE;
    localparam logic [MBITS:0] M_LIM = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_LIM = (NBITS+1)'(N);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam logic [2:0] ERR_BAD_OP     = 3'd1;
    localparam logic [2:0] ERR_BAD_SIZE   = 3'd2;
    localparam logic [2:0] ERR_NOT_LOADED = 3'd3;
    localparam logic [2:0] ERR_LOAD       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD_RUN,
        S_STORE_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   op_q;
    logic [MATRIX_REG_SIZE-1:0]   addr_q;
    logic [MBITS:0]               m_q;
    logic [NBITS:0]               n_q;
    logic [NREG-1:0]              reg_valid_q, reg_valid_d;
    logic [2:0]                   err_d;
    logic                         size_bad;
    logic                         accept;

`ifdef MPU_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen in the last allowed run cycle; the next edge times out.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    assign accept        = cmd_valid_in && cmd_ready_out;
    assign reg_valid_out = reg_valid_q;
    assign size_bad      = (m_q == '0) || (n_q == '0) || (m_q > M_LIM) || (n_q > N_LIM);

    // Next-state, error code and register-valid update.
    always_comb begin
        state_d     = state_q;
        err_d       = 3'd0;
        reg_valid_d = reg_valid_q;
`ifdef MPU_CTRL_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef MPU_CTRL_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (op_q == OP_NOP) begin
                    state_d = S_DONE;
                end else if (op_q != OP_LOAD && op_q != OP_STORE) begin
                    state_d = S_ERR;
                    err_d   = ERR_BAD_OP;
                end else if (size_bad) begin
                    state_d = S_ERR;
                    err_d   = ERR_BAD_SIZE;
                end else if (op_q == OP_STORE && !reg_valid_q[addr_q]) begin
                    state_d = S_ERR;
                    err_d   = ERR_NOT_LOADED;
                end else if (op_q == OP_LOAD) begin
                    state_d = S_LOAD_RUN;
                end else begin
                    state_d = S_STORE_RUN;
                end
            end
            S_LOAD_RUN: begin
                // A failed load leaves the register contents undefined, so its flag drops.
                if (mem_load_error_in) begin
                    state_d             = S_ERR;
                    err_d               = ERR_LOAD;
                    reg_valid_d[addr_q] = 1'b0;
                end else if (mem_load_ack_in) begin
                    state_d             = S_DONE;
                    reg_valid_d[addr_q] = 1'b1;
                end
`ifdef MPU_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d             = S_ERR;
                    err_d               = 3'd5;
                    reg_valid_d[addr_q] = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_STORE_RUN: begin
                if (reg_store_complete_in) begin
                    state_d = S_DONE;
                end
`ifdef MPU_CTRL_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 3'd5;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, command latch and registered outputs (decoded from the next state
    // so every output lines up with the state it describes).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= S_IDLE;
            op_q               <= 2'd0;
            addr_q             <= '0;
            m_q                <= '0;
            n_q                <= '0;
            reg_valid_q        <= '0;
            cmd_ready_out      <= 1'b1;
            load_en_out        <= 1'b0;
            store_en_out       <= 1'b0;
            reg_store_addr_out <= '0;
            busy_out           <= 1'b0;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
            err_code_out       <= 3'd0;
        end else begin
            state_q     <= state_d;
            reg_valid_q <= reg_valid_d;
            if (accept) begin
                op_q   <= cmd_op_in;
                addr_q <= cmd_addr_in;
                m_q    <= cmd_m_in;
                n_q    <= cmd_n_in;
            end
            cmd_ready_out <= (state_d == S_IDLE);
            busy_out      <= (state_d != S_IDLE);
            load_en_out   <= (state_d == S_LOAD_RUN);
            store_en_out  <= (state_d == S_STORE_RUN);
            done_out      <= (state_d == S_DONE);
            error_out     <= (state_d == S_ERR);
            err_code_out  <= (state_d == S_ERR) ? err_d : 3'd0;
            // Address is only updated on entry to STORE_RUN and held otherwise.
            if (state_d == S_STORE_RUN) begin
                reg_store_addr_out <= addr_q;
            end
        end
    end

`ifdef MPU_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mpu_ls_controller.sv
// Directed testbench for mpu_ls_controller with hand-computed expectations.
// Latency: checks done/error timing 2 cycles after accept and enable widths equal to ack delay.
// Backpressure: commands are only issued when the controller is idle.
module tb_mpu_ls_controller;

`ifdef MPU_CTRL_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 256;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid_in;
    logic       cmd_ready_out;
    logic [1:0] cmd_op_in;
    logic [1:0] cmd_addr_in;
    logic [2:0] cmd_m_in;
    logic [2:0] cmd_n_in;
    logic       load_en_out;
    logic       mem_load_ack_in;
    logic       mem_load_error_in;
    logic       store_en_out;
    logic [1:0] reg_store_addr_out;
    logic       reg_store_complete_in;
    logic       busy_out;
    logic       done_out;
    logic       error_out;
    logic [2:0] err_code_out;
    logic [3:0] reg_valid_out;

    int n_vec = 0;
    int n_bad = 0;

    mpu_ls_controller #(
        .M(4), .N(4), .MBITS(2), .NBITS(2), .MATRIX_REG_SIZE(2), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid_in          (cmd_valid_in),
        .cmd_ready_out         (cmd_ready_out),
        .cmd_op_in             (cmd_op_in),
        .cmd_addr_in           (cmd_addr_in),
        .cmd_m_in              (cmd_m_in),
        .cmd_n_in              (cmd_n_in),
        .load_en_out           (load_en_out),
        .mem_load_ack_in       (mem_load_ack_in),
        .mem_load_error_in     (mem_load_error_in),
        .store_en_out          (store_en_out),
        .reg_store_addr_out    (reg_store_addr_out),
        .reg_store_complete_in (reg_store_complete_in),
        .busy_out              (busy_out),
        .done_out              (done_out),
        .error_out             (error_out),
        .err_code_out          (err_code_out),
        .reg_valid_out         (reg_valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; controller is idle so it is accepted there.
    task automatic issue(input logic [1:0] op, input logic [1:0] addr,
                         input logic [2:0] m, input logic [2:0] n);
        chk("ready_before_issue", 32'(cmd_ready_out), 32'd1);
        cmd_valid_in = 1'b1;
        cmd_op_in    = op;
        cmd_addr_in  = addr;
        cmd_m_in     = m;
        cmd_n_in     = n;
        tick();
        cmd_valid_in = 1'b0;
        cmd_op_in    = 2'd0;
        cmd_addr_in  = 2'd0;
        cmd_m_in     = 3'd0;
        cmd_n_in     = 3'd0;
        chk("busy_in_check", 32'(busy_out), 32'd1);
        chk("ready_in_check", 32'(cmd_ready_out), 32'd0);
    endtask

    // Called in the cycle where the done/error pulse is expected.
    task automatic end_check(input string tag, input logic is_err, input logic [2:0] code);
        chk({tag, "_done"}, 32'(done_out), 32'(!is_err));
        chk({tag, "_error"}, 32'(error_out), 32'(is_err));
        chk({tag, "_code"}, 32'(err_code_out), 32'(code));
        tick();
        chk({tag, "_done_drop"}, 32'(done_out | error_out), 32'd0);
        chk({tag, "_code_drop"}, 32'(err_code_out), 32'd0);
        chk({tag, "_idle"}, 32'({cmd_ready_out, busy_out}), 32'b10);
    endtask

    task automatic reject(input string tag, input logic [1:0] op, input logic [1:0] addr,
                          input logic [2:0] m, input logic [2:0] n, input logic [2:0] code);
        issue(op, addr, m, n);
        tick();
        chk({tag, "_no_en"}, 32'({load_en_out, store_en_out}), 32'd0);
        end_check(tag, 1'b1, code);
    endtask

    // LOAD/STORE that sees ack/complete (optionally with load error) on run cycle d.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] addr,
                          input logic [2:0] m, input logic [2:0] n, input int d,
                          input logic err_in, input logic [2:0] code);
        int cnt;
        issue(op, addr, m, n);
        tick();
        cnt = 0;
        for (int i = 0; i < d; i++) begin
            cnt += (op == 2'd1) ? int'(load_en_out) : int'(store_en_out);
            if (i == 0 && op == 2'd2) chk({tag, "_store_addr"}, 32'(reg_store_addr_out), 32'(addr));
            if (i == d - 1) begin
                if (op == 2'd1) begin
                    mem_load_ack_in   = 1'b1;
                    mem_load_error_in = err_in;
                end else begin
                    reg_store_complete_in = 1'b1;
                end
            end
            tick();
        end
        mem_load_ack_in       = 1'b0;
        mem_load_error_in     = 1'b0;
        reg_store_complete_in = 1'b0;
        chk({tag, "_en_cycles"}, 32'(cnt), 32'(d));
        chk({tag, "_en_drop"}, 32'({load_en_out, store_en_out}), 32'd0);
        end_check(tag, code != 3'd0, code);
    endtask

    initial begin
        int cnt;
        rst                   = 1'b0;
        cmd_valid_in          = 1'b0;
        cmd_op_in             = 2'd0;
        cmd_addr_in           = 2'd0;
        cmd_m_in              = 3'd0;
        cmd_n_in              = 3'd0;
        mem_load_ack_in       = 1'b0;
        mem_load_error_in     = 1'b0;
        reg_store_complete_in = 1'b0;
        #12;
        chk("rst_ready", 32'(cmd_ready_out), 32'd1);
        chk("rst_outs", 32'({load_en_out, store_en_out, busy_out, done_out, error_out}), 32'd0);
        chk("rst_code", 32'(err_code_out), 32'd0);
        chk("rst_valid", 32'(reg_valid_out), 32'd0);
        chk("rst_store_addr", 32'(reg_store_addr_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // NOP: done two cycles after accept.
        issue(2'd0, 2'd2, 3'd0, 3'd0);
        tick();
        end_check("nop", 1'b0, 3'd0);

        run_op("load_a0", 2'd1, 2'd0, 3'd2, 3'd2, 4, 1'b0, 3'd0);
        chk("valid_after_load_a0", 32'(reg_valid_out), 32'h1);

        run_op("store_a0", 2'd2, 2'd0, 3'd2, 3'd2, 3, 1'b0, 3'd0);
        chk("valid_after_store_a0", 32'(reg_valid_out), 32'h1);

        reject("store_unloaded", 2'd2, 2'd1, 3'd2, 3'd2, 3'd3);
        reject("size_m0", 2'd1, 2'd1, 3'd0, 3'd2, 3'd2);
        reject("size_m5", 2'd1, 2'd1, 3'd5, 3'd4, 3'd2);
        reject("size_n5", 2'd2, 2'd0, 3'd4, 3'd5, 3'd2);
        reject("op_rsvd", 2'd3, 2'd0, 3'd2, 3'd2, 3'd1);
        chk("valid_after_rejects", 32'(reg_valid_out), 32'h1);

        run_op("load_a3_max", 2'd1, 2'd3, 3'd4, 3'd4, 1, 1'b0, 3'd0);
        chk("valid_after_load_a3", 32'(reg_valid_out), 32'h9);

        run_op("store_a3", 2'd2, 2'd3, 3'd1, 3'd1, 2, 1'b0, 3'd0);
        chk("store_addr_hold", 32'(reg_store_addr_out), 32'd3);

        run_op("load_err_ack", 2'd1, 2'd0, 3'd2, 3'd2, 2, 1'b1, 3'd4);
        chk("valid_after_load_err", 32'(reg_valid_out), 32'h8);
        chk("store_addr_hold2", 32'(reg_store_addr_out), 32'd3);

        // Stray acks while idle must not change anything.
        mem_load_ack_in       = 1'b1;
        reg_store_complete_in = 1'b1;
        tick();
        tick();
        mem_load_ack_in       = 1'b0;
        reg_store_complete_in = 1'b0;
        chk("idle_ack_valid", 32'(reg_valid_out), 32'h8);
        chk("idle_ack_busy", 32'({busy_out, done_out, error_out}), 32'd0);

        run_op("reload_a3", 2'd1, 2'd3, 3'd3, 3'd1, 2, 1'b0, 3'd0);
        chk("valid_after_reload", 32'(reg_valid_out), 32'h8);

        // LOAD with no ack.
        issue(2'd1, 2'd1, 3'd2, 3'd2);
        tick();
`ifdef MPU_CTRL_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < TO_CYC; i++) begin
            cnt += int'(load_en_out);
            tick();
        end
        chk("timeout_en_cycles", 32'(cnt), 32'(TO_CYC));
        end_check("timeout", 1'b1, 3'd5);
        issue(2'd1, 2'd1, 3'd2, 3'd2);
        tick();
`else
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cnt += int'(load_en_out & busy_out);
            tick();
        end
        chk("no_ack_stays_busy", 32'(cnt), 32'd20);
        chk("no_ack_no_pulse", 32'({done_out, error_out}), 32'd0);
`endif
        // Asynchronous reset mid-LOAD_RUN.
        chk("pre_rst_load_en", 32'(load_en_out), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_load_en", 32'(load_en_out), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        chk("mid_rst_valid", 32'(reg_valid_out), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready_out), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 32'({cmd_ready_out, busy_out, load_en_out}), 32'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
